// File: rtl/cnn_layer_accel_octo_sched_pkg.sv
// rtl/cnn_layer_accel_octo_sched_pkg.sv - shared types and sizing for the octo input scheduler
package cnn_layer_accel_octo_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEW_MAP,
    ST_SEQ_LOAD,
    ST_GAP,
    ST_PIX_LOAD,
    ST_DONE
  } sched_state_t;

  localparam int C_DIM_WIDTH_DEF = 10;

  // rows*cols needs twice the width of a single dimension
  function automatic int pix_cnt_width(input int dim_width);
    return 2 * dim_width;
  endfunction

  localparam int C_PIX_CNT_WIDTH = pix_cnt_width(C_DIM_WIDTH_DEF);

endpackage

// File: rtl/cnn_layer_accel_octo_input_sched.sv
// rtl/cnn_layer_accel_octo_input_sched.sv - sequences new_map, seq words and pixels onto the shared datain bus
module cnn_layer_accel_octo_input_sched
  import cnn_layer_accel_octo_sched_pkg::*;
#(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 14,
  parameter int C_DIM_WIDTH      = C_DIM_WIDTH_DEF,
  parameter int C_SEQ_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [C_DIM_WIDTH-1:0]     cfg_num_rows,
  input  logic [C_DIM_WIDTH-1:0]     cfg_num_cols,
  input  logic [C_SEQ_CNT_WIDTH-1:0] cfg_seq_count,
  output logic                       busy,
  output logic                       done,
  input  logic [C_SEQ_DATA_WIDTH-1:0] seq_in_data,
  input  logic                       seq_in_valid,
  output logic                       seq_in_rdy,
  input  logic [C_PIXEL_WIDTH-1:0]   pix_in_data,
  input  logic                       pix_in_valid,
  output logic                       pix_in_rdy,
  output logic                       new_map,
  output logic                       seq_datain_tag,
  input  logic                       seq_datain_rdy,
  output logic                       pixel_datain_tag,
  input  logic                       pixel_datain_rdy,
  output logic [C_PIXEL_WIDTH-1:0]   datain,
  output logic                       datain_valid
);

  localparam int PCW = pix_cnt_width(C_DIM_WIDTH);

  sched_state_t state, state_nxt;

  logic [C_SEQ_CNT_WIDTH-1:0] seq_cnt, seq_total;
  logic [PCW-1:0]             pix_cnt, pix_total;
  logic                       seq_xfer, pix_xfer, seq_last, pix_last;

  assign seq_xfer = (state == ST_SEQ_LOAD) && seq_in_valid && seq_datain_rdy;
  assign pix_xfer = (state == ST_PIX_LOAD) && pix_in_valid && pixel_datain_rdy;
  assign seq_last = (seq_cnt == seq_total - C_SEQ_CNT_WIDTH'(1));
  assign pix_last = (pix_cnt == pix_total - PCW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_NEW_MAP;
      ST_NEW_MAP:  state_nxt = (seq_total != '0) ? ST_SEQ_LOAD : ST_GAP;
      ST_SEQ_LOAD: if (seq_xfer && seq_last) state_nxt = ST_GAP;
      ST_GAP:      state_nxt = (pix_total != '0) ? ST_PIX_LOAD : ST_DONE;
      ST_PIX_LOAD: if (pix_xfer && pix_last) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Config is captured only on an accepted start; later changes wait for the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt   <= '0;
      pix_cnt   <= '0;
      seq_total <= '0;
      pix_total <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        seq_total <= cfg_seq_count;
        pix_total <= PCW'(cfg_num_rows) * PCW'(cfg_num_cols);
        seq_cnt   <= '0;
        pix_cnt   <= '0;
      end
      if (seq_xfer) seq_cnt <= seq_cnt + C_SEQ_CNT_WIDTH'(1);
      if (pix_xfer) pix_cnt <= pix_cnt + PCW'(1);
    end
  end

  always_comb begin
    busy             = (state != ST_IDLE);
    done             = 1'b0;
    new_map          = 1'b0;
    seq_datain_tag   = 1'b0;
    pixel_datain_tag = 1'b0;
    seq_in_rdy       = 1'b0;
    pix_in_rdy       = 1'b0;
    datain           = '0;
    datain_valid     = 1'b0;
    case (state)
      ST_NEW_MAP: new_map = 1'b1;
      ST_SEQ_LOAD: begin
        seq_datain_tag = 1'b1;
        datain         = C_PIXEL_WIDTH'(seq_in_data);
        datain_valid   = seq_in_valid;
        seq_in_rdy     = seq_datain_rdy;
      end
      ST_PIX_LOAD: begin
        pixel_datain_tag = 1'b1;
        datain           = pix_in_data;
        datain_valid     = pix_in_valid;
        pix_in_rdy       = pixel_datain_rdy;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// tb/tb_cnn_layer_accel_octo_input_sched.sv - table-driven bench for the octo input scheduler
module tb_cnn_layer_accel_octo_input_sched;

  localparam int PW = 16;
  localparam int SW = 14;
  localparam int DW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] cfg_num_rows, cfg_num_cols;
  logic [CW-1:0] cfg_seq_count;
  logic          busy, done;
  logic [SW-1:0] seq_in_data;
  logic          seq_in_valid, seq_in_rdy;
  logic [PW-1:0] pix_in_data;
  logic          pix_in_valid, pix_in_rdy;
  logic          new_map, seq_datain_tag, seq_datain_rdy;
  logic          pixel_datain_tag, pixel_datain_rdy;
  logic [PW-1:0] datain;
  logic          datain_valid;

  cnn_layer_accel_octo_input_sched #(
    .C_PIXEL_WIDTH(PW), .C_SEQ_DATA_WIDTH(SW), .C_DIM_WIDTH(DW), .C_SEQ_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols), .cfg_seq_count(cfg_seq_count),
    .busy(busy), .done(done),
    .seq_in_data(seq_in_data), .seq_in_valid(seq_in_valid), .seq_in_rdy(seq_in_rdy),
    .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_rdy(pix_in_rdy),
    .new_map(new_map), .seq_datain_tag(seq_datain_tag), .seq_datain_rdy(seq_datain_rdy),
    .pixel_datain_tag(pixel_datain_tag), .pixel_datain_rdy(pixel_datain_rdy),
    .datain(datain), .datain_valid(datain_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rows;
    int cols;
    int seqc;
    bit rnd;
    bit restart;
    int exp_seq;
    int exp_pix;
    int exp_done;
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] seq_word(input int k);
    return SW'(k * 37 + 5) ^ 14'h2a55;
  endfunction

  function automatic logic [PW-1:0] pix_word(input int k);
    return PW'(k * 1031 + 3) ^ 16'hc3a5;
  endfunction

  function automatic logic [PW+7:0] out_vec();
    return {busy, done, new_map, seq_datain_tag, pixel_datain_tag, datain_valid,
            seq_in_rdy, pix_in_rdy, datain};
  endfunction

  task automatic run_load(input vec_t v, input int abort_at);
    int seq_x = 0, pix_x = 0, nm_cnt = 0, nm_cyc = -1, done_cnt = 0, done_cyc = -1;
    int gap_cnt = 0, viol = 0, data_bad = 0, seq_tag_cyc = 0, pix_tag_cyc = 0;
    int abort_cyc = -1, busy_after_abort = 0;
    bit done_prev = 0, finished = 0, busy_at_done = 0, busy_after = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 0) || (v.restart && cyc == 4);
      if (cyc == 0) begin
        cfg_num_rows  = DW'(v.rows);
        cfg_num_cols  = DW'(v.cols);
        cfg_seq_count = CW'(v.seqc);
      end else begin
        cfg_num_rows  = DW'(7);
        cfg_num_cols  = DW'(3);
        cfg_seq_count = CW'(2);
      end
      seq_in_data      = seq_word(seq_x);
      pix_in_data      = pix_word(pix_x);
      seq_in_valid     = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_in_valid     = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      seq_datain_rdy   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_datain_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rst = (abort_at >= 0 && abort_cyc < 0 && pix_x == abort_at);
      if (rst) abort_cyc = cyc;
      #1;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1)
        check("abort_outputs_zero", longint'(out_vec()), 0);
      if (abort_cyc >= 0 && cyc > abort_cyc && busy) busy_after_abort++;
      if (new_map) begin nm_cnt++; nm_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
      if (seq_datain_tag && pixel_datain_tag) viol++;
      if (!seq_datain_tag && !pixel_datain_tag &&
          (datain != '0 || datain_valid || seq_in_rdy || pix_in_rdy)) viol++;
      if (busy && !new_map && !done && !seq_datain_tag && !pixel_datain_tag) gap_cnt++;
      if (seq_datain_tag) begin
        seq_tag_cyc++;
        if (datain_valid !== seq_in_valid || seq_in_rdy !== seq_datain_rdy) viol++;
        if (datain_valid && datain !== PW'(seq_word(seq_x))) data_bad++;
        if (datain_valid && seq_datain_rdy && !rst) seq_x++;
      end
      if (pixel_datain_tag) begin
        pix_tag_cyc++;
        if (datain_valid !== pix_in_valid || pix_in_rdy !== pixel_datain_rdy) viol++;
        if (datain_valid && datain !== pix_word(pix_x)) data_bad++;
        if (datain_valid && pixel_datain_rdy && !rst) pix_x++;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 6) break;
      if (done_prev) begin
        busy_after = busy;
        finished   = 1;
        break;
      end
      done_prev = done;
    end
    start = 1'b0;
    rst   = 1'b0;
    if (abort_at >= 0) begin
      check("abort_pix_count", pix_x, abort_at);
      check("abort_new_map_once", nm_cnt, 1);
      check("abort_no_done", done_cnt, 0);
      check("abort_busy_after", busy_after_abort, 0);
      check("abort_violations", viol, 0);
    end else begin
      check("done_reached", finished, 1);
      check("seq_transfers", seq_x, v.exp_seq);
      check("pix_transfers", pix_x, v.exp_pix);
      check("seq_tag_seen", seq_tag_cyc > 0, v.exp_seq > 0);
      check("pix_tag_seen", pix_tag_cyc > 0, v.exp_pix > 0);
      check("new_map_count", nm_cnt, 1);
      check("new_map_cycle", nm_cyc, 1);
      check("done_count", done_cnt, 1);
      check("gap_cycles", gap_cnt, 1);
      check("tag_bus_violations", viol, 0);
      check("data_order", data_bad, 0);
      check("busy_at_done", busy_at_done, 1);
      check("busy_after_done", busy_after, 0);
      if (v.exp_done >= 0) check("done_latency", done_cyc, v.exp_done);
    end
  endtask

  initial begin
    //          rows cols seqc rnd rst  seq  pix  done_cycle
    vecs[0] = '{10,  10,  50,  0,  0,   50,  100, 153};
    vecs[1] = '{10,  10,  50,  1,  0,   50,  100, -1};
    vecs[2] = '{2,   3,   0,   0,  0,   0,   6,   9};
    vecs[3] = '{0,   10,  5,   0,  1,   5,   0,   8};
    vecs[4] = '{1,   1,   1,   1,  0,   1,   1,   -1};
    vecs[5] = '{0,   0,   0,   0,  0,   0,   0,   3};

    rst = 1'b1; start = 1'b0;
    cfg_num_rows = '0; cfg_num_cols = '0; cfg_seq_count = '0;
    seq_in_data = '0; seq_in_valid = 1'b1; pix_in_data = '0; pix_in_valid = 1'b1;
    seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero", longint'(out_vec()), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_load(vecs[i], -1);

    run_load(vecs[0], 43);
    run_load(vecs[0], -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
